ascii_to_ps2_tx: RTL
====================

// Module: ascii_to_ps2_tx
// PURPOSE
//  Keyboard-side PS/2 transmitter: accepts one ASCII character, maps it to its
//  PS/2 scan-code-set-2 code and serialises make + break (code, F0, code) as
//  device-driven PS/2 frames. Emulates a keyboard toward the host-side
//  receive/decode path.
//  Sits between a character source (UART/test sequencer) and the PS/2 pins.
// PARAMETERS
//  HALF_PERIOD  4000   clk cycles per PS/2 clock half-phase (100 MHz -> 12.5 kHz)
//  FRAME_GAP    10000  idle clk cycles (lines high) after every frame
// PORTS
//  clk          in   1  system clock, all logic on rising edge
//  rst_n        in   1  asynchronous active-low reset
//  ascii        in   8  character to send
//  ascii_valid  in   1  ascii is valid this cycle
//  ascii_ready  out  1  block can accept a character
//  busy         out  1  character sequence in progress
//  err          out  1  1-cycle pulse: accepted char has no scan code, dropped
//  ps2_clk_o    out  1  PS/2 clock driven by device, idle 1
//  ps2_data_o   out  1  PS/2 data driven by device, idle 1
// BEHAVIOUR
//  Reset (async assert, sync release): FSM=IDLE, ascii_ready=1, busy=0, err=0,
//   ps2_clk_o=1, ps2_data_o=1, all counters 0. Mid-frame reset: lines go high
//   immediately, partial frame abandoned, no resume.
//  Handshake: accept when ascii_valid&&ascii_ready on a rising edge.
//   ascii_ready=1 only in IDLE; ascii is registered on acceptance.
//  Map (set 2): A-Z and a-z share one code (A=1C B=32 C=21 D=23 E=24 F=2B G=34
//   H=33 I=43 J=3B K=42 L=4B M=3A N=31 O=44 P=4D Q=15 R=2D S=1B T=2C U=3C V=2A
//   W=1D X=22 Y=35 Z=1A); 0-9 = 45 16 1E 26 25 2E 36 3D 3E 46; space 20->29;
//   CR 0D->5A. Anything else unsupported.
//  FSM: IDLE -> LOAD (1 cycle, lookup) -> SEND -> GAP -> SEND ... -> IDLE.
//   LOAD unsupported: err=1 for that cycle, go IDLE, no line activity.
//   LOAD supported: byte_idx=0, busy=1; bytes in order: code, F0, code.
//  Frame (11 bits): start 0, data[0..7] LSB first, odd parity (XOR of data
//   inverted), stop 1. Per bit i: HIGH phase ps2_clk_o=1, ps2_data_o=bit i for
//   HALF_PERIOD cycles; then LOW phase ps2_clk_o=0 for HALF_PERIOD cycles (data
//   held). Data changes only while clk high; host samples on falling edge.
//   Frame = 22*HALF_PERIOD cycles.
//  GAP: after LOW phase of stop bit, lines=1 for FRAME_GAP cycles; then
//   byte_idx<2 -> SEND next byte, byte_idx==2 -> IDLE (busy=0, ready=1).
//  Timing: ascii_ready re-asserts exactly 1+3*(22*HALF_PERIOD+FRAME_GAP) cycles
//   after the acceptance edge. ascii_valid held high then accepts next char on
//   that first ready cycle; no char is lost or duplicated.
//  Host clock inhibit (open-drain pull-low) not supported; outputs are levels
//   for a top-level open-drain buffer (drive 0 / release on 1).
//  Counters: half-phase counter sized for max(HALF_PERIOD,FRAME_GAP), bit
//   counter 0..10, byte_idx 0..2; no wrap beyond terminal values.
// TESTING  (bench uses HALF_PERIOD=4, FRAME_GAP=8)
//  'A'(41) -> frames 1C,F0,1C sampled on ps2_clk_o falls; parities 0,1,0;
//   ascii_ready back high 1+3*96=289 cycles after accept.
//  'a'(61) then '9'(39) held valid back-to-back -> 1C,F0,1C then 46,F0,46;
//   second accepted on first ready cycle.
//  '?'(3F) -> err pulse 1 cycle after accept, lines stay high, ready next cycle.
//  CR(0D) -> 5A,F0,5A; stop bit 1 and start bit 0 checked in each frame.
//  rst_n low during bit 4 of F0 frame -> ps2_clk_o=ps2_data_o=1 same cycle,
//   busy=0; after release 'Z' -> clean 1A,F0,1A.
//  Lines idle: no ps2_clk_o edge while IDLE over 1000 cycles with valid=0.

Source files
------------

// File: rtl/ascii_to_ps2_tx_if.sv
// rtl/ascii_to_ps2_tx_if.sv - character handshake bus between a character source and the PS/2 transmitter
interface ascii_to_ps2_tx_if;
    logic [7:0] ascii;
    logic       ascii_valid;
    logic       ascii_ready;
    logic       busy;
    logic       err;

    modport master (output ascii, ascii_valid, input ascii_ready, busy, err);
    modport slave  (input ascii, ascii_valid, output ascii_ready, busy, err);
endinterface

// File: rtl/ascii_to_ps2_tx.sv
// rtl/ascii_to_ps2_tx.sv - ASCII to PS/2 set-2 make/break keyboard-side transmitter
module ascii_to_ps2_tx #(
    parameter int HALF_PERIOD = 4000,
    parameter int FRAME_GAP   = 10000
) (
    input  logic              clk,
    input  logic              rst_n,
    ascii_to_ps2_tx_if.slave  char_if,
    output logic              ps2_clk_o,
    output logic              ps2_data_o
);
    localparam int CNT_MAX = (HALF_PERIOD > FRAME_GAP) ? HALF_PERIOD : FRAME_GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] HP_LAST  = CW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(FRAME_GAP - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

    state_t          state_q, state_d;
    logic [7:0]      ascii_q, ascii_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            low_q, low_d;
    logic [3:0]      bit_q, bit_d;
    logic [1:0]      byte_q, byte_d;

    logic            supported;
    logic [7:0]      code;
    logic [7:0]      cur_byte;
    logic [10:0]     frame;

    // Upper and lower case letters share one key, so fold to upper case first.
    function automatic logic [8:0] scan_lookup(input logic [7:0] c);
        logic [7:0] u;
        logic [8:0] r;
        u = (c >= 8'h61 && c <= 8'h7A) ? (c - 8'h20) : c;
        case (u)
            8'h41: r = {1'b1, 8'h1C};  8'h42: r = {1'b1, 8'h32};
            8'h43: r = {1'b1, 8'h21};  8'h44: r = {1'b1, 8'h23};
            8'h45: r = {1'b1, 8'h24};  8'h46: r = {1'b1, 8'h2B};
            8'h47: r = {1'b1, 8'h34};  8'h48: r = {1'b1, 8'h33};
            8'h49: r = {1'b1, 8'h43};  8'h4A: r = {1'b1, 8'h3B};
            8'h4B: r = {1'b1, 8'h42};  8'h4C: r = {1'b1, 8'h4B};
            8'h4D: r = {1'b1, 8'h3A};  8'h4E: r = {1'b1, 8'h31};
            8'h4F: r = {1'b1, 8'h44};  8'h50: r = {1'b1, 8'h4D};
            8'h51: r = {1'b1, 8'h15};  8'h52: r = {1'b1, 8'h2D};
            8'h53: r = {1'b1, 8'h1B};  8'h54: r = {1'b1, 8'h2C};
            8'h55: r = {1'b1, 8'h3C};  8'h56: r = {1'b1, 8'h2A};
            8'h57: r = {1'b1, 8'h1D};  8'h58: r = {1'b1, 8'h22};
            8'h59: r = {1'b1, 8'h35};  8'h5A: r = {1'b1, 8'h1A};
            8'h30: r = {1'b1, 8'h45};  8'h31: r = {1'b1, 8'h16};
            8'h32: r = {1'b1, 8'h1E};  8'h33: r = {1'b1, 8'h26};
            8'h34: r = {1'b1, 8'h25};  8'h35: r = {1'b1, 8'h2E};
            8'h36: r = {1'b1, 8'h36};  8'h37: r = {1'b1, 8'h3D};
            8'h38: r = {1'b1, 8'h3E};  8'h39: r = {1'b1, 8'h46};
            8'h20: r = {1'b1, 8'h29};  8'h0D: r = {1'b1, 8'h5A};
            default: r = 9'h000;
        endcase
        return r;
    endfunction

    assign {supported, code} = scan_lookup(ascii_q);
    assign cur_byte = (byte_q == 2'd1) ? 8'hF0 : code;
    assign frame    = {1'b1, ~^cur_byte, cur_byte, 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ascii_q <= '0;
            cnt_q   <= '0;
            low_q   <= 1'b0;
            bit_q   <= '0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            ascii_q <= ascii_d;
            cnt_q   <= cnt_d;
            low_q   <= low_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ascii_d = ascii_q;
        cnt_d   = cnt_q;
        low_d   = low_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        case (state_q)
            IDLE: begin
                if (char_if.ascii_valid) begin
                    ascii_d = char_if.ascii;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                low_d   = 1'b0;
                bit_d   = '0;
                byte_d  = '0;
                state_d = supported ? SEND : IDLE;
            end
            SEND: begin
                if (cnt_q == HP_LAST) begin
                    cnt_d = '0;
                    if (!low_q) begin
                        low_d = 1'b1;
                    end else begin
                        low_d = 1'b0;
                        if (bit_q == 4'd10) state_d = GAP;
                        else                bit_d   = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (byte_q == 2'd2) begin
                        state_d = IDLE;
                    end else begin
                        byte_d  = byte_q + 2'd1;
                        bit_d   = '0;
                        state_d = SEND;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Data only moves at bit boundaries, which always fall in a clock-high phase.
    assign ps2_clk_o           = !((state_q == SEND) && low_q);
    assign ps2_data_o          = (state_q == SEND) ? frame[bit_q] : 1'b1;
    assign char_if.ascii_ready = (state_q == IDLE);
    assign char_if.busy        = (state_q == SEND) || (state_q == GAP) ||
                                 ((state_q == LOAD) && supported);
    assign char_if.err         = (state_q == LOAD) && !supported;
endmodule
